// File: rtl/core_alu.sv
// core_alu: single-cycle x86-64 integer execute unit with a registered 128-bit result and RFLAGS image.
// Define ALU_MUL_EN to build the MUL/IMUL datapath; otherwise opcodes 20/21 decode as undefined.
module core_alu #(
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          opcode,
  input  logic [DATA_W-1:0]   oprd1,
  input  logic [DATA_W-1:0]   oprd2,
  input  logic [DATA_W-1:0]   oprd3,
  output logic [2*DATA_W-1:0] result,
  output logic [63:0]         flags,
  output logic                valid
);

  localparam int unsigned FLAG_W = 64;
  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned MSB    = DATA_W - 1;
  localparam logic [FLAG_W-1:0] FLAGS_RST = FLAG_W'(2);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_MOV  = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_ADC  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_SBB  = 8'h05;
  localparam logic [7:0] OP_CMP  = 8'h06;
  localparam logic [7:0] OP_AND  = 8'h07;
  localparam logic [7:0] OP_OR   = 8'h08;
  localparam logic [7:0] OP_XOR  = 8'h09;
  localparam logic [7:0] OP_TEST = 8'h0A;
  localparam logic [7:0] OP_NOT  = 8'h0B;
  localparam logic [7:0] OP_NEG  = 8'h0C;
  localparam logic [7:0] OP_INC  = 8'h0D;
  localparam logic [7:0] OP_DEC  = 8'h0E;
  localparam logic [7:0] OP_SHL  = 8'h10;
  localparam logic [7:0] OP_SHR  = 8'h11;
  localparam logic [7:0] OP_SAR  = 8'h12;
`ifdef ALU_MUL_EN
  localparam logic [7:0] OP_MUL  = 8'h20;
  localparam logic [7:0] OP_IMUL = 8'h21;
`endif

  logic [2*DATA_W-1:0] result_q, result_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                valid_q;

  logic [DATA_W-1:0] ax, bx;
  logic              ci;
  logic [DATA_W:0]   add_w, sub_w;
  logic [DATA_W-1:0] add_x, sub_x;
  logic              add_of, sub_of;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   shl_w, shr_w, sar_w;
  logic [DATA_W-1:0] wb, hi, fv;
  logic              cf, of, af, upd;
  logic              unused_oprd3;

  assign unused_oprd3 = ^oprd3[DATA_W-1:1];

  function automatic logic [FLAG_W-1:0] pack_flags(input logic [DATA_W-1:0] v,
                                                    input logic c, input logic o, input logic a);
    logic [FLAG_W-1:0] f;
    f     = FLAGS_RST;
    f[0]  = c;
    f[2]  = ~^v[7:0];
    f[4]  = a;
    f[6]  = (v == '0);
    f[7]  = v[MSB];
    f[11] = o;
    return f;
  endfunction

  // Shared adder/subtractor operands; INC/DEC/NEG reuse the same datapath.
  always_comb begin
    ax = oprd1;
    bx = oprd2;
    ci = 1'b0;
    case (opcode)
      OP_ADC, OP_SBB: ci = oprd3[0];
      OP_INC, OP_DEC: bx = DATA_W'(1);
      OP_NEG: begin
        ax = '0;
        bx = oprd1;
      end
      default: ;
    endcase
  end

  assign add_w  = {1'b0, ax} + {1'b0, bx} + (DATA_W+1)'(ci);
  assign sub_w  = {1'b0, ax} - {1'b0, bx} - (DATA_W+1)'(ci);
  assign add_x  = ax ^ bx ^ add_w[MSB:0];
  assign sub_x  = ax ^ bx ^ sub_w[MSB:0];
  // Overflow = carry/borrow into MSB differs from carry/borrow out; exact even with carry-in.
  assign add_of = add_x[MSB] ^ add_w[DATA_W];
  assign sub_of = sub_x[MSB] ^ sub_w[DATA_W];

  assign cnt   = oprd2[CNT_W-1:0];
  assign shl_w = {1'b0, oprd1} << cnt;
  assign shr_w = {oprd1, 1'b0} >> cnt;
  assign sar_w = $signed({oprd1, 1'b0}) >>> cnt;

`ifdef ALU_MUL_EN
  logic [2*DATA_W-1:0] prod_u, prod_s;
  assign prod_u = {{DATA_W{1'b0}}, oprd1} * {{DATA_W{1'b0}}, oprd2};
  assign prod_s = $signed({{DATA_W{oprd1[MSB]}}, oprd1}) * $signed({{DATA_W{oprd2[MSB]}}, oprd2});
`endif

  // Opcode decode: writeback value, flag source value and flag bits.
  always_comb begin
    wb  = '0;
    hi  = '0;
    fv  = '0;
    cf  = 1'b0;
    of  = 1'b0;
    af  = 1'b0;
    upd = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_MOV: wb = oprd2;
      OP_ADD, OP_ADC, OP_INC: begin
        wb  = add_w[MSB:0];
        fv  = wb;
        cf  = (opcode == OP_INC) ? flags_q[0] : add_w[DATA_W];
        of  = add_of;
        af  = add_x[4];
        upd = 1'b1;
      end
      OP_SUB, OP_SBB, OP_CMP, OP_DEC, OP_NEG: begin
        wb  = (opcode == OP_CMP) ? oprd1 : sub_w[MSB:0];
        fv  = sub_w[MSB:0];
        cf  = (opcode == OP_DEC) ? flags_q[0] :
              (opcode == OP_NEG) ? (|oprd1) : sub_w[DATA_W];
        of  = sub_of;
        af  = sub_x[4];
        upd = 1'b1;
      end
      OP_AND: begin
        wb  = oprd1 & oprd2;
        fv  = wb;
        upd = 1'b1;
      end
      OP_OR: begin
        wb  = oprd1 | oprd2;
        fv  = wb;
        upd = 1'b1;
      end
      OP_XOR: begin
        wb  = oprd1 ^ oprd2;
        fv  = wb;
        upd = 1'b1;
      end
      OP_TEST: begin
        wb  = oprd1;
        fv  = oprd1 & oprd2;
        upd = 1'b1;
      end
      OP_NOT: wb = ~oprd1;
      OP_SHL: begin
        wb = oprd1;
        if (cnt != '0) begin
          wb  = shl_w[MSB:0];
          fv  = wb;
          cf  = shl_w[DATA_W];
          of  = (cnt == CNT_W'(1)) && (wb[MSB] != oprd1[MSB]);
          upd = 1'b1;
        end
      end
      OP_SHR: begin
        wb = oprd1;
        if (cnt != '0) begin
          wb  = shr_w[DATA_W:1];
          fv  = wb;
          cf  = shr_w[0];
          of  = (cnt == CNT_W'(1)) && oprd1[MSB];
          upd = 1'b1;
        end
      end
      OP_SAR: begin
        wb = oprd1;
        if (cnt != '0) begin
          wb  = sar_w[DATA_W:1];
          fv  = wb;
          cf  = sar_w[0];
          upd = 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        wb  = prod_u[MSB:0];
        hi  = prod_u[2*DATA_W-1:DATA_W];
        fv  = wb;
        cf  = |hi;
        of  = cf;
        upd = 1'b1;
      end
      OP_IMUL: begin
        wb  = prod_s[MSB:0];
        hi  = prod_s[2*DATA_W-1:DATA_W];
        fv  = wb;
        cf  = (hi != {DATA_W{wb[MSB]}});
        of  = cf;
        upd = 1'b1;
      end
`endif
      default: ;
    endcase
    result_d = {hi, wb};
    flags_d  = upd ? pack_flags(fv, cf, of, af) : flags_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= FLAGS_RST;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= enable;
      if (enable) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_core_alu.sv
// tb_core_alu: directed and randomized checks of core_alu against an arithmetic reference model.
module tb_core_alu;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [7:0]   opcode;
  logic [63:0]  oprd1, oprd2, oprd3;
  logic [127:0] result;
  logic [63:0]  flags;
  logic         valid;

  int checks = 0;
  int errors = 0;

  logic [127:0] m_result;
  logic [63:0]  m_flags;
  logic         m_valid;

  logic [7:0] op_list [0:22] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h10,
                                 8'h11, 8'h12, 8'h20, 8'h21, 8'h0F, 8'h13, 8'hFF};

  core_alu dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .opcode (opcode),
    .oprd1  (oprd1),
    .oprd2  (oprd2),
    .oprd3  (oprd3),
    .result (result),
    .flags  (flags),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".result"}, result, m_result);
    chk({tag, ".flags"}, 128'(flags), 128'(m_flags));
    chk({tag, ".valid"}, 128'(valid), 128'(m_valid));
  endtask

  function automatic logic [63:0] mkf(input logic [63:0] v, input bit cf, input bit of, input bit af);
    logic [63:0] f;
    f     = 64'h2;
    f[0]  = cf;
    f[2]  = (($countones(v[7:0]) % 2) == 0);
    f[4]  = af;
    f[6]  = (v == 64'd0);
    f[7]  = v[63];
    f[11] = of;
    return f;
  endfunction

  // True-value arithmetic: flags judged by range checks on wide integers.
  task automatic arith(input logic [63:0] a, input logic [63:0] b, input bit is_sub, input bit cin,
                       output logic [63:0] r, output bit cf, output bit of, output bit af);
    logic signed [127:0] sa, sb, sw;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    if (!is_sub) begin
      r  = a + b + 64'(cin);
      cf = ({64'd0, a} + {64'd0, b} + 128'(cin)) > 128'hFFFF_FFFF_FFFF_FFFF;
      sw = sa + sb + 128'(cin);
      af = (int'(a[3:0]) + int'(b[3:0]) + int'(cin)) > 15;
    end else begin
      r  = a - b - 64'(cin);
      cf = {64'd0, a} < ({64'd0, b} + 128'(cin));
      sw = sa - sb - 128'(cin);
      af = int'(a[3:0]) < (int'(b[3:0]) + int'(cin));
    end
    of = (sw > 128'sh7FFF_FFFF_FFFF_FFFF) || (sw < -128'sh8000_0000_0000_0000);
  endtask

  task automatic ref_exec(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] fin,
                          output logic [127:0] r, output logic [63:0] fo);
    logic [63:0] lo, hi, fv;
    bit cf, of, af, upd;
    int n;
`ifdef ALU_MUL_EN
    logic [127:0]        pu;
    logic signed [127:0] ps;
`endif
    lo = '0; hi = '0; fv = '0; cf = 0; of = 0; af = 0; upd = 0;
    n  = int'(b[5:0]);
    case (op)
      8'h01: lo = b;
      8'h02, 8'h03: begin arith(a, b, 0, (op == 8'h03) && c[0], lo, cf, of, af); fv = lo; upd = 1; end
      8'h04, 8'h05: begin arith(a, b, 1, (op == 8'h05) && c[0], lo, cf, of, af); fv = lo; upd = 1; end
      8'h06: begin arith(a, b, 1, 0, fv, cf, of, af); lo = a; upd = 1; end
      8'h07: begin lo = a & b; fv = lo; upd = 1; end
      8'h08: begin lo = a | b; fv = lo; upd = 1; end
      8'h09: begin lo = a ^ b; fv = lo; upd = 1; end
      8'h0A: begin fv = a & b; lo = a; upd = 1; end
      8'h0B: lo = ~a;
      8'h0C: begin arith(64'd0, a, 1, 0, lo, cf, of, af); cf = (a != 64'd0); fv = lo; upd = 1; end
      8'h0D: begin arith(a, 64'd1, 0, 0, lo, cf, of, af); cf = fin[0]; fv = lo; upd = 1; end
      8'h0E: begin arith(a, 64'd1, 1, 0, lo, cf, of, af); cf = fin[0]; fv = lo; upd = 1; end
      8'h10: if (n == 0) lo = a; else begin
        lo = a << n; cf = a[64-n]; of = (n == 1) && (lo[63] != a[63]); fv = lo; upd = 1;
      end
      8'h11: if (n == 0) lo = a; else begin
        lo = a >> n; cf = a[n-1]; of = (n == 1) && a[63]; fv = lo; upd = 1;
      end
      8'h12: if (n == 0) lo = a; else begin
        lo = a >> n;
        if (a[63]) lo = lo | ~(64'hFFFF_FFFF_FFFF_FFFF >> n);
        cf = a[n-1]; fv = lo; upd = 1;
      end
`ifdef ALU_MUL_EN
      8'h20: begin
        pu = {64'd0, a} * {64'd0, b};
        lo = pu[63:0]; hi = pu[127:64];
        cf = pu > 128'hFFFF_FFFF_FFFF_FFFF; of = cf; fv = lo; upd = 1;
      end
      8'h21: begin
        ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        lo = ps[63:0]; hi = ps[127:64];
        cf = (ps > 128'sh7FFF_FFFF_FFFF_FFFF) || (ps < -128'sh8000_0000_0000_0000);
        of = cf; fv = lo; upd = 1;
      end
`endif
      default: ;
    endcase
    r  = {hi, lo};
    fo = upd ? mkf(fv, cf, of, af) : fin;
  endtask

  task automatic model_step();
    logic [127:0] r;
    logic [63:0]  f;
    if (enable) begin
      ref_exec(opcode, oprd1, oprd2, oprd3, m_flags, r, f);
      m_result = r;
      m_flags  = f;
      m_valid  = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_op(input bit en, input logic [7:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input string tag);
    enable = en; opcode = op; oprd1 = a; oprd2 = b; oprd3 = c;
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] a, b, c;
    logic [7:0]  op;
    bit          en;
    reset = 1'b1; enable = 1'b0; opcode = '0; oprd1 = '0; oprd2 = '0; oprd3 = '0;
    m_result = '0; m_flags = 64'h2; m_valid = 1'b0;
    #12;
    check_outputs("reset");
    reset = 1'b0;

    do_op(1, 8'h02, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, "add_wrap");
    chk("add_wrap.k_result", result, 128'd0);
    chk("add_wrap.k_flags", 128'(flags), 128'h57);
    do_op(1, 8'h04, 64'd5, 64'd7, 64'd0, "sub_neg");
    chk("sub_neg.k_result", result, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE);
    chk("sub_neg.k_flags", 128'(flags), 128'h93);
    do_op(1, 8'h06, 64'd5, 64'd7, 64'd0, "cmp");
    chk("cmp.k_result", result, 128'd5);
    chk("cmp.k_flags", 128'(flags), 128'h93);
    do_op(1, 8'h02, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, "add_ovf");
    chk("add_ovf.k_flags", 128'(flags), 128'h896);
    do_op(1, 8'h0D, 64'd0, 64'd0, 64'd0, "inc0");
    chk("inc0.k_result", result, 128'd1);
    chk("inc0.k_flags", 128'(flags), 128'h2);
    do_op(1, 8'h10, 64'h8000_0000_0000_0001, 64'd1, 64'd0, "shl1");
    chk("shl1.k_result", result, 128'd2);
    chk("shl1.k_flags", 128'(flags), 128'h803);
    do_op(1, 8'h10, 64'd2, 64'd0, 64'd0, "shl0");
    chk("shl0.k_result", result, 128'd2);
    chk("shl0.k_flags", 128'(flags), 128'h803);
`ifdef ALU_MUL_EN
    do_op(1, 8'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, "mul");
    chk("mul.k_result", result, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE);
    chk("mul.k_flags", 128'(flags), 128'h883);
    do_op(1, 8'h21, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, "imul");
    chk("imul.k_result", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    chk("imul.k_flags", 128'(flags), 128'h82);
`else
    do_op(1, 8'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, "mul_undef");
    chk("mul_undef.k_result", result, 128'd0);
`endif

    // Reset raised between operand issue and the clock edge.
    do_op(1, 8'h09, 64'h1234, 64'h00FF, 64'd0, "pre_reset");
    enable = 1'b1; opcode = 8'h02; oprd1 = 64'd3; oprd2 = 64'd4;
    #2 reset = 1'b1;
    #1;
    m_result = '0; m_flags = 64'h2; m_valid = 1'b0;
    check_outputs("reset_async");
    chk("reset_async.k_flags", 128'(flags), 128'h2);
    #3 reset = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) do_op(0, 8'h02, 64'd3, 64'd4, 64'd0, "idle_hold");

    for (int i = 0; i < 500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      op = op_list[$urandom_range(0, 22)];
      a  = rnd_val();
      b  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 2)) : rnd_val();
      c  = {$urandom, $urandom};
      do_op(en, op, a, b, c, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
